// File: rtl/mmc1_pkg.sv
// Shared definitions for the MMC1 serial-load write sequencer: register selects,
// mapper reset constants and the sequencer/bus-phase state encodings.
package mmc1_pkg;

    localparam logic [1:0] MMC1_REG_CTRL = 2'b00;
    localparam logic [1:0] MMC1_REG_CHR0 = 2'b01;
    localparam logic [1:0] MMC1_REG_CHR1 = 2'b10;
    localparam logic [1:0] MMC1_REG_PRG  = 2'b11;

    localparam logic [4:0] MMC1_CTRL_RESET   = 5'b01100;
    localparam logic [4:0] MMC1_PRG_FIX_MASK = 5'b01100;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RSTW = 2'd1,
        SEQ_BITW = 2'd2
    } seq_state_e;

    typedef enum logic [1:0] {
        PH_SETUP   = 2'd0,
        PH_HIGH    = 2'd1,
        PH_HOLD    = 2'd2,
        PH_RECOVER = 2'd3
    } bus_phase_e;

endpackage

// File: rtl/mmc1_write_sequencer_if.sv
// Requester handshakes, cartridge bus drive and shadow mirrors of the MMC1 write sequencer.
// slave = sequencer side, master = requesters / bus observer side.
interface mmc1_write_sequencer_if;

    logic       REQ0;
    logic [1:0] REQ0_SEL;
    logic [4:0] REQ0_DATA;
    logic       REQ0_RST;
    logic       ACK0;
    logic       REQ1;
    logic [1:0] REQ1_SEL;
    logic [4:0] REQ1_DATA;
    logic       REQ1_RST;
    logic       ACK1;
    logic       BUSY;
    logic       BUS_M2;
    logic       BUS_nROMSEL;
    logic       BUS_nRW;
    logic       BUS_A14;
    logic       BUS_A13;
    logic       BUS_D0;
    logic       BUS_D7;
    logic [4:0] SHADOW_CTRL;
    logic [4:0] SHADOW_CHR0;
    logic [4:0] SHADOW_CHR1;
    logic [4:0] SHADOW_PRG;

    modport slave (
        input  REQ0, REQ0_SEL, REQ0_DATA, REQ0_RST,
        input  REQ1, REQ1_SEL, REQ1_DATA, REQ1_RST,
        output ACK0, ACK1, BUSY,
        output BUS_M2, BUS_nROMSEL, BUS_nRW, BUS_A14, BUS_A13, BUS_D0, BUS_D7,
        output SHADOW_CTRL, SHADOW_CHR0, SHADOW_CHR1, SHADOW_PRG
    );

    modport master (
        output REQ0, REQ0_SEL, REQ0_DATA, REQ0_RST,
        output REQ1, REQ1_SEL, REQ1_DATA, REQ1_RST,
        input  ACK0, ACK1, BUSY,
        input  BUS_M2, BUS_nROMSEL, BUS_nRW, BUS_A14, BUS_A13, BUS_D0, BUS_D7,
        input  SHADOW_CTRL, SHADOW_CHR0, SHADOW_CHR1, SHADOW_PRG
    );

endinterface

// File: rtl/mmc1_rr_arbiter.sv
// Two-way round-robin arbiter; the pointer remembers the last winner so a
// simultaneous request goes to the other requester.
module mmc1_rr_arbiter (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    input  logic req0_i,
    input  logic req1_i,
    output logic gnt_valid_o,
    output logic gnt_idx_o
);

    logic last_q;

    // Grant decision, only while the sequencer is idle.
    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = 1'b0;
        if (en_i) begin
            case ({req1_i, req0_i})
                2'b01: begin
                    gnt_valid_o = 1'b1;
                    gnt_idx_o   = 1'b0;
                end
                2'b10: begin
                    gnt_valid_o = 1'b1;
                    gnt_idx_o   = 1'b1;
                end
                2'b11: begin
                    gnt_valid_o = 1'b1;
                    gnt_idx_o   = ~last_q;
                end
                default: begin
                    gnt_valid_o = 1'b0;
                    gnt_idx_o   = 1'b0;
                end
            endcase
        end else begin
            gnt_valid_o = 1'b0;
            gnt_idx_o   = 1'b0;
        end
    end

    // Last-granted pointer; reset value 1 makes requester 0 win the first tie.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_q <= 1'b1;
        end else if (gnt_valid_o) begin
            last_q <= gnt_idx_o;
        end
    end

endmodule

// File: rtl/mmc1_write_sequencer_chk.sv
// Parameter legality checks for the MMC1 write sequencer.
module mmc1_write_sequencer_chk #(
    parameter int M2_HIGH = 3,
    parameter int GAP_CYC = 4
) (
    input logic clk_i
);

    // A write needs at least one M2-high cycle; counters are 4 bits wide.
    always @(posedge clk_i) begin
        assert (M2_HIGH >= 1 && M2_HIGH <= 15);
        assert (GAP_CYC >= 0 && GAP_CYC <= 15);
    end

endmodule

// File: rtl/mmc1_write_sequencer.sv
// MMC1 serial-load write sequencer: arbitrates two requesters and emits an optional
// reset write plus five LSB-first D0 writes. Optional shadow registers: MMC1_SHADOW_EN.
module mmc1_write_sequencer
    import mmc1_pkg::*;
#(
    parameter int M2_HIGH = 3,
    parameter int GAP_CYC = 4
) (
    input logic                   CLK,
    input logic                   nRESET,
    mmc1_write_sequencer_if.slave bus
);

    localparam logic [3:0] M2_HIGH_C = 4'(M2_HIGH);
    localparam logic [3:0] GAP_C     = 4'(GAP_CYC);

    seq_state_e state_q;
    bus_phase_e phase_q;
    logic [3:0] cnt_q;
    logic [2:0] bit_q;
    logic [4:0] sh_q;
    logic       owner_q;
    logic       m2_q, nromsel_q, nrw_q, a14_q, a13_q, d0_q, d7_q;
    logic       busy_q, ack0_q, ack1_q;

    logic       gnt_valid_s, gnt_idx_s, gnt_rst_s, wr_done_s;
    logic [1:0] gnt_sel_s;
    logic [4:0] gnt_data_s;

    mmc1_rr_arbiter u_arb (
        .clk_i       (CLK),
        .rst_n_i     (nRESET),
        .en_i        (state_q == SEQ_IDLE),
        .req0_i      (bus.REQ0),
        .req1_i      (bus.REQ1),
        .gnt_valid_o (gnt_valid_s),
        .gnt_idx_o   (gnt_idx_s)
    );

    mmc1_write_sequencer_chk #(
        .M2_HIGH (M2_HIGH),
        .GAP_CYC (GAP_CYC)
    ) u_chk (
        .clk_i (CLK)
    );

    // Transaction fields of the requester that wins arbitration.
    always_comb begin
        gnt_sel_s  = bus.REQ0_SEL;
        gnt_data_s = bus.REQ0_DATA;
        gnt_rst_s  = bus.REQ0_RST;
        if (gnt_idx_s) begin
            gnt_sel_s  = bus.REQ1_SEL;
            gnt_data_s = bus.REQ1_DATA;
            gnt_rst_s  = bus.REQ1_RST;
        end else begin
            gnt_sel_s  = bus.REQ0_SEL;
            gnt_data_s = bus.REQ0_DATA;
            gnt_rst_s  = bus.REQ0_RST;
        end
    end

    // Last cycle of a bus write: end of RECOVER, or HOLD itself when there is no gap.
    always_comb begin
        wr_done_s = 1'b0;
        case (phase_q)
            PH_HOLD:    wr_done_s = (GAP_C == 4'd0);
            PH_RECOVER: wr_done_s = (cnt_q == GAP_C);
            default:    wr_done_s = 1'b0;
        endcase
    end

    // Sequencer FSM with registered bus drivers and handshakes.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q   <= SEQ_IDLE;
            phase_q   <= PH_SETUP;
            cnt_q     <= 4'd0;
            bit_q     <= 3'd0;
            sh_q      <= 5'd0;
            owner_q   <= 1'b0;
            m2_q      <= 1'b0;
            nromsel_q <= 1'b1;
            nrw_q     <= 1'b1;
            a14_q     <= 1'b0;
            a13_q     <= 1'b0;
            d0_q      <= 1'b0;
            d7_q      <= 1'b0;
            busy_q    <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            case (state_q)
                SEQ_IDLE: begin
                    if (gnt_valid_s) begin
                        state_q         <= gnt_rst_s ? SEQ_RSTW : SEQ_BITW;
                        phase_q         <= PH_SETUP;
                        bit_q           <= 3'd0;
                        sh_q            <= gnt_data_s;
                        owner_q         <= gnt_idx_s;
                        {a14_q, a13_q}  <= gnt_sel_s;
                        d7_q            <= gnt_rst_s;
                        d0_q            <= gnt_rst_s ? 1'b0 : gnt_data_s[0];
                        busy_q          <= 1'b1;
                    end
                end
                default: begin
                    case (phase_q)
                        PH_SETUP: begin
                            phase_q   <= PH_HIGH;
                            cnt_q     <= 4'd1;
                            m2_q      <= 1'b1;
                            nromsel_q <= 1'b0;
                            nrw_q     <= 1'b0;
                        end
                        PH_HIGH: begin
                            if (cnt_q == M2_HIGH_C) begin
                                phase_q <= PH_HOLD;
                                m2_q    <= 1'b0;
                            end else begin
                                cnt_q <= cnt_q + 4'd1;
                            end
                        end
                        PH_HOLD: begin
                            if (GAP_C != 4'd0) begin
                                phase_q   <= PH_RECOVER;
                                cnt_q     <= 4'd1;
                                nromsel_q <= 1'b1;
                                nrw_q     <= 1'b1;
                            end
                        end
                        PH_RECOVER: begin
                            if (cnt_q != GAP_C) begin
                                cnt_q <= cnt_q + 4'd1;
                            end
                        end
                        default: phase_q <= PH_SETUP;
                    endcase
                    // Overrides the phase step above when this write is complete.
                    if (wr_done_s) begin
                        phase_q   <= PH_SETUP;
                        m2_q      <= 1'b0;
                        nromsel_q <= 1'b1;
                        nrw_q     <= 1'b1;
                        if (state_q == SEQ_RSTW) begin
                            state_q <= SEQ_BITW;
                            bit_q   <= 3'd0;
                            d7_q    <= 1'b0;
                            d0_q    <= sh_q[0];
                        end else if (bit_q != 3'd4) begin
                            bit_q <= bit_q + 3'd1;
                            d0_q  <= sh_q[1];
                            sh_q  <= {1'b0, sh_q[4:1]};
                        end else begin
                            state_q <= SEQ_IDLE;
                            busy_q  <= 1'b0;
                            a14_q   <= 1'b0;
                            a13_q   <= 1'b0;
                            d0_q    <= 1'b0;
                            d7_q    <= 1'b0;
                            ack0_q  <= ~owner_q;
                            ack1_q  <= owner_q;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.ACK0        = ack0_q;
    assign bus.ACK1        = ack1_q;
    assign bus.BUSY        = busy_q;
    assign bus.BUS_M2      = m2_q;
    assign bus.BUS_nROMSEL = nromsel_q;
    assign bus.BUS_nRW     = nrw_q;
    assign bus.BUS_A14     = a14_q;
    assign bus.BUS_A13     = a13_q;
    assign bus.BUS_D0      = d0_q;
    assign bus.BUS_D7      = d7_q;

`ifdef MMC1_SHADOW_EN
    logic [4:0] data_q;
    logic [4:0] sh_ctrl_q, sh_chr0_q, sh_chr1_q, sh_prg_q;

    // Full register value kept for the shadow, since sh_q is consumed bit by bit.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            data_q <= 5'd0;
        end else if (gnt_valid_s) begin
            data_q <= gnt_data_s;
        end
    end

    // Mirror of mapper state, committed at the HOLD (M2 falling) cycle.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            sh_ctrl_q <= MMC1_CTRL_RESET;
            sh_chr0_q <= 5'd0;
            sh_chr1_q <= 5'd0;
            sh_prg_q  <= 5'd0;
        end else if (phase_q == PH_HOLD && state_q == SEQ_RSTW) begin
            sh_ctrl_q <= sh_ctrl_q | MMC1_PRG_FIX_MASK;
        end else if (phase_q == PH_HOLD && state_q == SEQ_BITW && bit_q == 3'd4) begin
            case ({a14_q, a13_q})
                MMC1_REG_CTRL: sh_ctrl_q <= data_q;
                MMC1_REG_CHR0: sh_chr0_q <= data_q;
                MMC1_REG_CHR1: sh_chr1_q <= data_q;
                MMC1_REG_PRG:  sh_prg_q  <= data_q;
                default:       sh_prg_q  <= sh_prg_q;
            endcase
        end
    end

    assign bus.SHADOW_CTRL = sh_ctrl_q;
    assign bus.SHADOW_CHR0 = sh_chr0_q;
    assign bus.SHADOW_CHR1 = sh_chr1_q;
    assign bus.SHADOW_PRG  = sh_prg_q;
`else
    assign bus.SHADOW_CTRL = 5'd0;
    assign bus.SHADOW_CHR0 = 5'd0;
    assign bus.SHADOW_CHR1 = 5'd0;
    assign bus.SHADOW_PRG  = 5'd0;
`endif

endmodule

// File: tb/tb_mmc1_write_sequencer.sv
// Directed bench for mmc1_write_sequencer: default timing instance plus a
// M2_HIGH=1 / GAP_CYC=0 instance; shadow expectations follow MMC1_SHADOW_EN.
module tb_mmc1_write_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mmc1_write_sequencer_if if_a ();
    mmc1_write_sequencer_if if_b ();

    mmc1_write_sequencer u_dut (
        .CLK    (clk),
        .nRESET (rst_n),
        .bus    (if_a.slave)
    );

    mmc1_write_sequencer #(.M2_HIGH(1), .GAP_CYC(0)) u_fast (
        .CLK    (clk),
        .nRESET (rst_n),
        .bus    (if_b.slave)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] shadow_exp(input logic [4:0] v);
`ifdef MMC1_SHADOW_EN
        return v;
`else
        return 5'd0;
`endif
    endfunction

    function automatic logic [4:0] shadow_of(input logic [1:0] sel);
        case (sel)
            2'b00:   return if_a.SHADOW_CTRL;
            2'b01:   return if_a.SHADOW_CHR0;
            2'b10:   return if_a.SHADOW_CHR1;
            default: return if_a.SHADOW_PRG;
        endcase
    endfunction

    // One full transaction on instance A, tracking every M2 fall until the ACK.
    task automatic run_req(input bit which, input logic [1:0] sel, input logic [4:0] data,
                           input bit rst, input string tag);
        int         c0, lat, falls, addr_err;
        logic [5:0] d0s, d7s;
        logic       prev_m2, busy_first, ack;
        bit         got_ack;
        @(negedge clk);
        if (which) begin
            if_a.REQ1 = 1'b1; if_a.REQ1_SEL = sel; if_a.REQ1_DATA = data; if_a.REQ1_RST = rst;
        end else begin
            if_a.REQ0 = 1'b1; if_a.REQ0_SEL = sel; if_a.REQ0_DATA = data; if_a.REQ0_RST = rst;
        end
        c0 = cyc; prev_m2 = if_a.BUS_M2; falls = 0; addr_err = 0;
        d0s = 6'd0; d7s = 6'd0; got_ack = 1'b0; lat = 0; busy_first = 1'b0;
        for (int i = 0; i < 200 && !got_ack; i++) begin
            @(negedge clk);
            if (i == 0) busy_first = if_a.BUSY;
            if (prev_m2 && !if_a.BUS_M2) begin
                if (falls < 6) begin
                    d0s[falls] = if_a.BUS_D0;
                    d7s[falls] = if_a.BUS_D7;
                end
                if ({if_a.BUS_A14, if_a.BUS_A13} !== sel || if_a.BUS_nROMSEL !== 1'b0) addr_err++;
                falls++;
            end
            prev_m2 = if_a.BUS_M2;
            ack = which ? if_a.ACK1 : if_a.ACK0;
            if (ack) begin
                got_ack = 1'b1;
                lat = cyc - c0;
                check_eq({tag, "_busy_in_ack"}, if_a.BUSY, 0);
                check_eq({tag, "_shadow"}, shadow_of(sel), shadow_exp(data));
                if (which) if_a.REQ1 = 1'b0; else if_a.REQ0 = 1'b0;
            end
        end
        check_eq({tag, "_ack_seen"}, got_ack, 1);
        check_eq({tag, "_latency"}, lat, rst ? 55 : 46);
        check_eq({tag, "_falls"}, falls, rst ? 6 : 5);
        check_eq({tag, "_d0_seq"}, d0s, rst ? {data, 1'b0} : {1'b0, data});
        check_eq({tag, "_d7_seq"}, d7s, rst ? 6'b000001 : 6'b000000);
        check_eq({tag, "_addr_err"}, addr_err, 0);
        check_eq({tag, "_busy_setup"}, busy_first, 1);
        @(negedge clk);
        check_eq({tag, "_ack_one_cycle"}, which ? if_a.ACK1 : if_a.ACK0, 0);
    endtask

    initial begin
        int c0, lat, rises, acks, falls, last_fall, spacing_err, low_cnt;
        logic prev_m2;
        bit done;
        rst_n = 1'b0;
        if_a.REQ0 = 1'b0; if_a.REQ0_SEL = 2'b00; if_a.REQ0_DATA = 5'd0; if_a.REQ0_RST = 1'b0;
        if_a.REQ1 = 1'b0; if_a.REQ1_SEL = 2'b00; if_a.REQ1_DATA = 5'd0; if_a.REQ1_RST = 1'b0;
        if_b.REQ0 = 1'b0; if_b.REQ0_SEL = 2'b00; if_b.REQ0_DATA = 5'd0; if_b.REQ0_RST = 1'b0;
        if_b.REQ1 = 1'b0; if_b.REQ1_SEL = 2'b00; if_b.REQ1_DATA = 5'd0; if_b.REQ1_RST = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_bus", {if_a.BUS_M2, if_a.BUS_nROMSEL, if_a.BUS_nRW, if_a.BUS_A14,
                             if_a.BUS_A13, if_a.BUS_D0, if_a.BUS_D7}, 7'b0110000);
        check_eq("rst_hs", {if_a.ACK0, if_a.ACK1, if_a.BUSY}, 3'b000);
        check_eq("rst_shadow_ctrl", if_a.SHADOW_CTRL, shadow_exp(5'b01100));
        check_eq("rst_shadow_prg", if_a.SHADOW_PRG, 5'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_req(1'b0, 2'b11, 5'b10110, 1'b0, "req0_prg");
        run_req(1'b1, 2'b00, 5'b00011, 1'b1, "req1_ctrl_rst");

        // Simultaneous requests: REQ0 first, REQ1 granted in REQ0's ACK cycle
        @(negedge clk);
        if_a.REQ0 = 1'b1; if_a.REQ0_SEL = 2'b10; if_a.REQ0_DATA = 5'b10101; if_a.REQ0_RST = 1'b0;
        if_a.REQ1 = 1'b1; if_a.REQ1_SEL = 2'b01; if_a.REQ1_DATA = 5'b00110; if_a.REQ1_RST = 1'b0;
        c0 = cyc; lat = 0; done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (if_a.ACK0 || if_a.ACK1) begin
                done = 1'b1;
                lat = cyc - c0;
                check_eq("arb_first_ack", {if_a.ACK0, if_a.ACK1}, 2'b10);
                check_eq("arb_busy_gap", if_a.BUSY, 0);
                if_a.REQ0 = 1'b0;
            end
        end
        check_eq("arb_lat0", lat, 46);
        @(negedge clk);
        check_eq("arb_busy_resume", if_a.BUSY, 1);
        check_eq("arb_req1_addr", {if_a.BUS_A14, if_a.BUS_A13}, 2'b01);
        done = 1'b0; lat = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (if_a.ACK1) begin
                done = 1'b1;
                lat = cyc - c0;
                if_a.REQ1 = 1'b0;
            end
        end
        check_eq("arb_lat1", lat, 92);
        check_eq("arb_shadow_chr0", if_a.SHADOW_CHR0, shadow_exp(5'b00110));

        // Reset during the third HIGH phase aborts with no ACK
        @(negedge clk);
        if_a.REQ0 = 1'b1; if_a.REQ0_SEL = 2'b10; if_a.REQ0_DATA = 5'b11111; if_a.REQ0_RST = 1'b0;
        rises = 0; prev_m2 = if_a.BUS_M2;
        for (int i = 0; i < 200 && rises < 3; i++) begin
            @(negedge clk);
            if (!prev_m2 && if_a.BUS_M2) rises++;
            prev_m2 = if_a.BUS_M2;
        end
        check_eq("abort_reached_high3", rises, 3);
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort_bus_idle", {if_a.BUS_M2, if_a.BUS_nROMSEL, if_a.BUS_nRW, if_a.BUSY}, 4'b0110);
        if_a.REQ0 = 1'b0;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (if_a.ACK0 || if_a.ACK1) acks++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (if_a.ACK0 || if_a.ACK1) acks++;
        end
        check_eq("abort_no_ack", acks, 0);
        check_eq("abort_shadow_chr1", if_a.SHADOW_CHR1, 5'd0);
        run_req(1'b0, 2'b01, 5'b01001, 1'b1, "post_abort");

        // M2_HIGH=1, GAP_CYC=0 instance: 3-cycle write period
        @(negedge clk);
        if_b.REQ0 = 1'b1; if_b.REQ0_SEL = 2'b11; if_b.REQ0_DATA = 5'b01101; if_b.REQ0_RST = 1'b0;
        c0 = cyc; lat = 0; done = 1'b0; falls = 0; last_fall = 0; spacing_err = 0; low_cnt = 0;
        prev_m2 = if_b.BUS_M2;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (!if_b.BUS_nROMSEL) begin
                low_cnt++;
                if (!if_b.BUS_M2 && !prev_m2) spacing_err++;
            end
            if (prev_m2 && !if_b.BUS_M2) begin
                if (falls > 0 && (cyc - last_fall) != 3) spacing_err++;
                if (falls < 5 && if_b.BUS_D0 !== if_b.REQ0_DATA[falls]) spacing_err++;
                last_fall = cyc;
                falls++;
            end
            prev_m2 = if_b.BUS_M2;
            if (if_b.ACK0) begin
                done = 1'b1;
                lat = cyc - c0;
                if_b.REQ0 = 1'b0;
            end
        end
        check_eq("fast_latency", lat, 16);
        check_eq("fast_falls", falls, 5);
        check_eq("fast_timing_err", spacing_err, 0);
        check_eq("fast_nromsel_low", low_cnt, 10);
        check_eq("fast_shadow_prg", if_b.SHADOW_PRG, shadow_exp(5'b01101));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
